// File: rtl/fetch_mmu.sv
// fetch_mmu: instruction fetch MMU with alignment/range checks, a software-loaded
// fully associative TLB, and a registered, optionally byte-swapped cache return.
module fetch_mmu #(
   parameter int INSTRUCTIONSIZE = 128,
   parameter int PADDR_WIDTH     = 56,
   parameter int PAGE_BITS       = 12,
   parameter int TLB_ENTRIES     = 4,
   parameter bit SWAP_BYTES      = 1'b1
) (
   input  logic                                                     clk,
   input  logic                                                     rst,
   input  logic [63:0]                                              address,
   input  logic                                                     doFetch,
   output logic [INSTRUCTIONSIZE-1:0]                               instruction,
   output logic                                                     doneFetch,
   output logic                                                     fault,
   output logic [1:0]                                               faultCause,
   input  logic                                                     translateEnable,
   input  logic                                                     tlbWrite,
   input  logic [(TLB_ENTRIES > 1 ? $clog2(TLB_ENTRIES) : 1)-1:0]   tlbIndex,
   input  logic [63-PAGE_BITS:0]                                    tlbVpn,
   input  logic [PADDR_WIDTH-PAGE_BITS-1:0]                         tlbPpn,
   input  logic                                                     tlbFlush,
   output logic [PADDR_WIDTH-1:0]                                   cacheAddress,
   output logic                                                     cacheFetch,
   input  logic [INSTRUCTIONSIZE-1:0]                               cacheData,
   input  logic                                                     cacheDone
);
   localparam int NB = INSTRUCTIONSIZE / 8;
   localparam logic [63:0] ALIGN_MASK = 64'(NB - 1);
   typedef enum logic [1:0] {IDLE, LOOKUP, CACHE, DONE} state_t;
   state_t                           state_q, state_d;
   logic [63:0]                      addr_q, addr_d;
   logic                             xlate_q, xlate_d;
   logic [INSTRUCTIONSIZE-1:0]       instr_q, instr_d;
   logic                             fault_q, fault_d;
   logic [1:0]                       cause_q, cause_d;
   logic [PADDR_WIDTH-1:0]           caddr_q, caddr_d;
   logic [TLB_ENTRIES-1:0]           valid_q, valid_d;
   logic [63-PAGE_BITS:0]            tlb_vpn_q [TLB_ENTRIES];
   logic [PADDR_WIDTH-PAGE_BITS-1:0] tlb_ppn_q [TLB_ENTRIES];
   logic                             wr_ok, hit;
   logic [PADDR_WIDTH-PAGE_BITS-1:0] hit_ppn;
   logic [PADDR_WIDTH-1:0]           phys;
   logic [1:0]                       lk_cause;
   logic [INSTRUCTIONSIZE-1:0]       swapped, captured;
   for (genvar b = 0; b < NB; b++) begin : g_swap
      assign swapped[8*b +: 8] = cacheData[INSTRUCTIONSIZE-8-8*b +: 8];
   end
   assign captured = SWAP_BYTES ? swapped : cacheData;
   assign wr_ok    = tlbWrite && (32'(tlbIndex) < TLB_ENTRIES);
   // A flush and a write in the same cycle leave the written entry valid.
   assign valid_d  = (tlbFlush ? '0 : valid_q) | (wr_ok ? TLB_ENTRIES'(1) << tlbIndex : '0);
   // Scanning downward lets the lowest matching index win.
   always_comb begin
      hit     = 1'b0;
      hit_ppn = '0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--)
         if (valid_q[i] && tlb_vpn_q[i] == addr_q[63:PAGE_BITS]) begin
            hit     = 1'b1;
            hit_ppn = tlb_ppn_q[i];
         end
   end
   assign phys     = xlate_q ? {hit_ppn, addr_q[PAGE_BITS-1:0]} : addr_q[PADDR_WIDTH-1:0];
   assign lk_cause = (addr_q & ALIGN_MASK) != 64'd0             ? 2'd1 :
                     (!xlate_q && (addr_q >> PADDR_WIDTH) != 0) ? 2'd2 :
                     (xlate_q && !hit)                          ? 2'd3 : 2'd0;
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      xlate_d = xlate_q;
      instr_d = instr_q;
      fault_d = fault_q;
      cause_d = cause_q;
      caddr_d = caddr_q;
      case (state_q)
         IDLE: if (doFetch) begin
            addr_d  = address;
            xlate_d = translateEnable;
            state_d = LOOKUP;
         end
         LOOKUP: begin
            fault_d = lk_cause != 2'd0;
            cause_d = lk_cause;
            caddr_d = lk_cause != 2'd0 ? caddr_q : phys;
            state_d = lk_cause != 2'd0 ? DONE : CACHE;
         end
         CACHE: if (cacheDone) begin
            instr_d = captured;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         xlate_q <= 1'b0;
         instr_q <= '0;
         fault_q <= 1'b0;
         cause_q <= 2'd0;
         caddr_q <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         xlate_q <= xlate_d;
         instr_q <= instr_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
         caddr_q <= caddr_d;
         valid_q <= valid_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         tlb_vpn_q[tlbIndex] <= tlbVpn;
         tlb_ppn_q[tlbIndex] <= tlbPpn;
      end
   end
   assign instruction  = instr_q;
   assign doneFetch    = state_q == DONE;
   assign fault        = fault_q;
   assign faultCause   = cause_q;
   assign cacheFetch   = state_q == CACHE;
   assign cacheAddress = caddr_q;
endmodule

// File: doc/fetch_mmu.md
Name: fetch_mmu

Overview:
- Parametrised next-generation instruction fetch MMU between the fetch stage and the instruction cache.
- Checks each fetch address for alignment and range faults.
- Optionally translates it through a small fully associative, software-loaded TLB.
- Issues the physical fetch to the cache, and returns a registered, optionally byte-reversed instruction with a done/fault handshake.

Parameters:
- INSTRUCTIONSIZE, 128: instruction width in bits; must be a multiple of 8 and a power of two.
- PADDR_WIDTH, 56: physical address width driven to the cache.
- PAGE_BITS, 12: page offset width.
- TLB_ENTRIES, 4: number of TLB entries, 1..16.
- SWAP_BYTES, 1: 1 = reverse byte order of cache data (big-endian memory); 0 = pass through.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- address  in  64  virtual fetch address.
- doFetch  in  1  fetch request; sampled only in IDLE.
- instruction  out  INSTRUCTIONSIZE  fetched instruction, registered.
- doneFetch  out  1  one-cycle completion pulse.
- fault  out  1  valid with doneFetch; 1 = fetch faulted.
- faultCause  out  2  valid with fault: 1 misaligned, 2 out of range, 3 TLB miss.
- translateEnable  in  1  1 = use TLB; sampled with doFetch.
- tlbWrite  in  1  write TLB entry this cycle.
- tlbIndex  in  $clog2(TLB_ENTRIES) (min 1)  entry to write.
- tlbVpn  in  64-PAGE_BITS  virtual page number.
- tlbPpn  in  PADDR_WIDTH-PAGE_BITS  physical page number.
- tlbFlush  in  1  invalidate all entries.
- cacheAddress  out  PADDR_WIDTH  physical address; stable while cacheFetch is high.
- cacheFetch  out  1  cache request; held until cacheDone.
- cacheData  in  INSTRUCTIONSIZE  cache data; valid when cacheDone is high.
- cacheDone  in  1  cache completion.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE; all TLB valid bits cleared.
  - instruction=0, doneFetch=0, fault=0, faultCause=0, cacheFetch=0, cacheAddress=0.
  - Reset mid-fetch abandons the request; no doneFetch is produced.
- States: IDLE, LOOKUP, CACHE, DONE.
- IDLE:
  - On doFetch=1, latch address and translateEnable; next state LOOKUP.
  - doFetch in any other state is ignored. The requester holds doFetch until doneFetch.
- LOOKUP (one cycle; checks in priority order):
  - Misaligned: address[$clog2(INSTRUCTIONSIZE/8)-1:0] != 0 → cause 1.
  - Out of range (translate off): address[63:PADDR_WIDTH] != 0 → cause 2.
  - TLB miss (translate on): no valid entry with vpn == address[63:PAGE_BITS] → cause 3.
  - TLB hit: physical = {ppn, address[PAGE_BITS-1:0]}. If several entries hit, the lowest index wins.
  - Translate off: physical = address[PADDR_WIDTH-1:0].
  - Any fault → DONE with fault=1, cache not accessed. Otherwise → CACHE with cacheAddress loaded.
- CACHE:
  - cacheFetch=1 and cacheAddress held constant.
  - On cacheDone=1, capture cacheData (byte-reversed when SWAP_BYTES=1: byte 0 ↔ byte N-1) into instruction; next state DONE.
  - cacheFetch drops in the cycle after cacheDone. There is no timeout.
- DONE:
  - doneFetch=1 for exactly one cycle; fault/faultCause valid; next state IDLE.
  - instruction holds its value until the next successful capture; it is not updated on faults.
- Latency:
  - doFetch sampled at edge N: LOOKUP in cycle N+1, cacheFetch high from cycle N+2.
  - cacheDone in cycle M → doneFetch in cycle M+1.
  - Fault → doneFetch in cycle N+2.
  - Back-to-back: a new doFetch is accepted in the IDLE cycle after DONE.
- TLB:
  - Written on the clock edge when tlbWrite=1 (sets valid). Usable by a LOOKUP in the next cycle or later.
  - A write in the same cycle as LOOKUP is not visible to that lookup.
  - tlbFlush clears all valid bits. If tlbFlush and tlbWrite occur together, the written entry ends valid.
  - Writes and flushes are accepted in every state.

Test Plan:
- SWAP_BYTES=1, translate off, address=0x1000; cache returns 0x00112233445566778899AABBCCDDEEFF after 3 cycles → cacheAddress=0x1000; instruction=0xFFEEDDCCBBAA99887766554433221100; doneFetch exactly 1 cycle, fault=0; latency matches the spec.
- address=0x1004 → doneFetch with fault=1, cause=1 in cycle N+2; cacheFetch never asserted; instruction unchanged.
- Translate off, address=0x0100_0000_0000_0000 → fault cause 2.
- Write entry 2 with vpn=0x12345, ppn=0xABC; fetch 0x12345010 with translate on → cacheAddress=0xABC010. Then tlbFlush and refetch → fault cause 3.
- Entries 0 and 3 with the same vpn and ppns 0x1 and 0x2 → cacheAddress uses ppn 0x1. Write entry 0 in the LOOKUP cycle → old mapping used.
- Assert rst while in CACHE → cacheFetch=0 immediately, no doneFetch, TLB empty; a subsequent fetch completes normally.
